imem_prog_controller: RTL



---
 rtl/imem_prog_pkg.sv | 29 ++
 rtl/imem_port_mux.sv | 22 ++
 rtl/imem_prog_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/imem_prog_pkg.sv
// Shared types for the IMEM UART loader: FSM states, error codes, port request.
package imem_prog_pkg;

   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CNT_LO,
      S_CNT_HI,
      S_DATA,
      S_CSUM,
      S_END
   } prog_state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_BAD_CNT = 2'd1,
      ERR_TIMEOUT = 2'd2,
      ERR_CSUM    = 2'd3
   } prog_err_t;

   typedef struct packed {
      logic        en;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] din;
   } imem_req_t;

endpackage

// File: rtl/imem_port_mux.sv
// Combinational IMEM port arbiter: loader owns the port while prog_ena is high.
module imem_port_mux
   import imem_prog_pkg::*;
(
   input  logic        prog_ena,
   input  imem_req_t   ld_req,
   input  logic        fetch_en,
   input  logic [31:0] fetch_addr,
   output imem_req_t   port_req
);

   always_comb begin
      port_req = '0;
      if (prog_ena) begin
         port_req = ld_req;
      end else begin
         port_req.en   = fetch_en;
         port_req.addr = fetch_addr;
      end
   end

endmodule

// File: rtl/imem_prog_controller.sv
// UART frame loader for IMEM: sync, LE word count, LE words, XOR checksum.
module imem_prog_controller
   import imem_prog_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          TIMEOUT_CYC = 100000
)(
   input  logic        clk,
   input  logic        Rst_n,
   input  logic        uart_valid,
   input  logic [7:0]  uart_dout,
   input  logic        fetch_en,
   input  logic [31:0] fetch_addr,
   output logic        imem_en,
   output logic [3:0]  imem_we,
   output logic [31:0] imem_addr,
   output logic [31:0] imem_din,
   output logic        prog_ena,
   output logic        prog_done,
   output logic [1:0]  prog_err,
   output logic [15:0] words_loaded
);

   localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LIM   = TW'(TIMEOUT_CYC);
   localparam logic [16:0]   DEPTH_LIM = 17'(DEPTH_WORDS);

   prog_state_t   state;
   prog_err_t     err_q;
   logic [7:0]    cnt_lo;
   logic [15:0]   word_cnt;
   logic [15:0]   cnt_full;
   logic [31:0]   asm_word;
   logic [1:0]    byte_idx;
   logic [7:0]    csum;
   logic [TW-1:0] tmo_cnt;
   logic          tmo_fire;
   logic          wr_vld;
   logic [31:0]   wr_addr;
   logic [31:0]   wr_data;
   imem_req_t     ld_req;
   imem_req_t     port_req;

   assign cnt_full = {uart_dout, cnt_lo};
   assign prog_err = err_q;

   // Timeout only applies between bytes of a frame; it overrides a same-cycle byte.
   assign tmo_fire = (state != S_IDLE) && (state != S_END) && (tmo_cnt == TMO_LIM);

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state        <= S_IDLE;
         err_q        <= ERR_NONE;
         prog_ena     <= 1'b0;
         prog_done    <= 1'b0;
         words_loaded <= '0;
         cnt_lo       <= '0;
         word_cnt     <= '0;
         asm_word     <= '0;
         byte_idx     <= '0;
         csum         <= '0;
         tmo_cnt      <= '0;
         wr_vld       <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
      end else begin
         wr_vld    <= 1'b0;
         prog_done <= 1'b0;
         if (state == S_IDLE || uart_valid)
            tmo_cnt <= '0;
         else if (tmo_cnt != TMO_LIM)
            tmo_cnt <= tmo_cnt + 1'b1;

         if (tmo_fire) begin
            err_q    <= ERR_TIMEOUT;
            prog_ena <= 1'b0;
            state    <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: if (uart_valid && uart_dout == SYNC_BYTE) begin
                  state        <= S_CNT_LO;
                  prog_ena     <= 1'b1;
                  err_q        <= ERR_NONE;
                  words_loaded <= '0;
                  csum         <= '0;
                  byte_idx     <= '0;
                  asm_word     <= '0;
               end
               S_CNT_LO: if (uart_valid) begin
                  cnt_lo <= uart_dout;
                  state  <= S_CNT_HI;
               end
               S_CNT_HI: if (uart_valid) begin
                  word_cnt <= cnt_full;
                  if ({1'b0, cnt_full} > DEPTH_LIM) begin
                     err_q    <= ERR_BAD_CNT;
                     prog_ena <= 1'b0;
                     state    <= S_IDLE;
                  end else if (cnt_full == 16'd0) begin
                     state <= S_CSUM;
                  end else begin
                     state <= S_DATA;
                  end
               end
               S_DATA: if (uart_valid) begin
                  // Bytes shift in from the top so the 4th byte completes {b3,b2,b1,b0}.
                  csum     <= csum ^ uart_dout;
                  byte_idx <= byte_idx + 2'd1;
                  asm_word <= {uart_dout, asm_word[31:8]};
                  if (byte_idx == 2'd3) begin
                     wr_vld       <= 1'b1;
                     wr_addr      <= BASE_ADDR + {14'b0, words_loaded, 2'b00};
                     wr_data      <= {uart_dout, asm_word[31:8]};
                     words_loaded <= words_loaded + 16'd1;
                     if (words_loaded + 16'd1 == word_cnt)
                        state <= S_CSUM;
                  end
               end
               S_CSUM: if (uart_valid) begin
                  prog_ena <= 1'b0;
                  if (uart_dout == csum) begin
                     prog_done <= 1'b1;
                     state     <= S_END;
                  end else begin
                     err_q <= ERR_CSUM;
                     state <= S_IDLE;
                  end
               end
               S_END:   state <= S_IDLE;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign ld_req = '{en: wr_vld, we: {4{wr_vld}}, addr: wr_addr, din: wr_data};

   imem_port_mux u_mux (
      .prog_ena   (prog_ena),
      .ld_req     (ld_req),
      .fetch_en   (fetch_en),
      .fetch_addr (fetch_addr),
      .port_req   (port_req)
   );

   assign imem_en   = port_req.en;
   assign imem_we   = port_req.we;
   assign imem_addr = port_req.addr;
   assign imem_din  = port_req.din;

endmodule
